// File: rtl/icache_mem_responder.sv
// Direct-mapped, write-through, no-write-allocate cache (4 words/line) answering Rd/Wr requests.
// Misses fill from a req/ack word memory. ICACHE_MEM_RESPONDER_STATS_EN adds hit/miss counters.
module icache_mem_responder #(
    parameter  int IDX_W = 3,
    localparam int TAG_W = 16 - IDX_W - 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
`ifdef ICACHE_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int LINES = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_t;

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic [1:0]         cnt_d;
    logic [15:1]        req_addr_q;
    logic               wr_hit_q;
    logic               resp_q;
    logic               resp_hit_q;
    logic               resp_rd_q;
    logic               stall_q;
    logic               mem_rd_q;
    logic               mem_wr_q;
    logic [15:0]        mem_addr_q;
    logic [15:0]        mem_wdata_q;
    logic [LINES-1:0]   valid_q;

    logic [15:0]        data_mem [LINES*4];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic [IDX_W-1:0]   in_idx;
    logic [1:0]         in_off;
    logic [TAG_W-1:0]   in_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [1:0]         req_off;
    logic [TAG_W-1:0]   req_tag;

    logic               is_idle;
    logic               req_err;
    logic               legal_rd;
    logic               in_hit;
    logic               rd_hit;
    logic               rd_miss_go;
    logic               wr_go;

    assign in_idx  = Addr[3+IDX_W-1:3];
    assign in_off  = Addr[2:1];
    assign in_tag  = Addr[15:3+IDX_W];
    assign req_idx = req_addr_q[3+IDX_W-1:3];
    assign req_off = req_addr_q[2:1];
    assign req_tag = req_addr_q[15:3+IDX_W];

    assign is_idle    = (state_q == IDLE);
    assign req_err    = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
    assign legal_rd   = Rd && !Wr && !Addr[0];
    assign in_hit     = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
    assign rd_hit     = is_idle && legal_rd && in_hit;
    assign rd_miss_go = is_idle && legal_rd && !in_hit;
    assign wr_go      = is_idle && Wr && !Rd && !Addr[0];
    assign cnt_d      = cnt_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            req_addr_q  <= '0;
            wr_hit_q    <= 1'b0;
            resp_q      <= 1'b0;
            resp_hit_q  <= 1'b0;
            resp_rd_q   <= 1'b0;
            stall_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_miss_go) begin
                        // The line is overwritten word by word, so it must not look valid mid-fill.
                        state_q         <= FILL;
                        req_addr_q      <= Addr[15:1];
                        cnt_q           <= 2'd0;
                        valid_q[in_idx] <= 1'b0;
                        stall_q         <= 1'b1;
                        mem_rd_q        <= 1'b1;
                        mem_addr_q      <= {Addr[15:3], 3'b000};
                    end else if (wr_go) begin
                        state_q     <= WRITE;
                        req_addr_q  <= Addr[15:1];
                        wr_hit_q    <= in_hit;
                        stall_q     <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= Addr;
                        mem_wdata_q <= DataIn;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 2'd3) begin
                            valid_q[req_idx] <= 1'b1;
                            state_q          <= RESP;
                            stall_q          <= 1'b0;
                            mem_rd_q         <= 1'b0;
                            resp_q           <= 1'b1;
                            resp_hit_q       <= 1'b0;
                            resp_rd_q        <= 1'b1;
                        end else begin
                            mem_addr_q <= {req_addr_q[15:3], cnt_d, 1'b0};
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state_q    <= RESP;
                        stall_q    <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        resp_q     <= 1'b1;
                        resp_hit_q <= wr_hit_q;
                        resp_rd_q  <= 1'b0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage; write hits and fill words never coincide since they belong to different states.
    always_ff @(posedge clk) begin
        if (wr_go && in_hit) begin
            data_mem[{in_idx, in_off}] <= DataIn;
        end else if (state_q == FILL && mem_ack) begin
            data_mem[{req_idx, cnt_q}] <= mem_rdata;
            if (cnt_q == 2'd3) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
    end

    always_comb begin
        DataOut = '0;
        if (resp_q && resp_rd_q) begin
            DataOut = data_mem[{req_idx, req_off}];
        end else if (rd_hit) begin
            DataOut = data_mem[{in_idx, in_off}];
        end
    end

    assign Done      = resp_q || (is_idle && (req_err || rd_hit));
    assign err       = is_idle && req_err;
    assign CacheHit  = resp_q ? resp_hit_q : rd_hit;
    assign Stall     = stall_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ICACHE_MEM_RESPONDER_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (Done && CacheHit && hit_count_q != 16'hFFFF) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
            if (Done && !CacheHit && !err && miss_count_q != 16'hFFFF) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_mem_responder.sv
// Bench for icache_mem_responder: directed scenarios then random traffic, checked against
// a line-residency model plus a backing-memory array that the cache must mirror.
module tb_icache_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    icache_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          ack_delay = 2;
    int          wait_cnt;
    bit          saw_req;
    logic [15:0] mem_model [0:32767];
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    int          ref_line [0:7];   // resident line number (Addr>>3) per index, -1 = empty
    logic [15:0] last_data;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory: acks ack_delay cycles after a request is seen, logs every handshake.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        saw_req   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_rd || mem_wr) begin
                saw_req = 1'b1;
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (mem_rd) begin
                        mem_rdata = mem_model[mem_addr[15:1]];
                        rd_log.push_back(mem_addr);
                    end else begin
                        mem_model[mem_addr[15:1]] = mem_wdata;
                        wr_addr_log.push_back(mem_addr);
                        wr_data_log.push_back(mem_wdata);
                    end
                end
            end
        end
    end

    task automatic xact(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input string name);
        int          idx;
        int          line;
        int          cyc;
        bit          is_err;
        bit          resident;
        bit          got;
        int          exp_reads;
        int          exp_writes;
        logic [15:0] exp_data;
        logic        o_hit;
        logic        o_err;
        logic        o_stall;
        logic [15:0] o_data;
        idx       = int'(a[5:3]);
        line      = int'(a[15:3]);
        is_err    = (rd && wr) || ((rd || wr) && a[0]);
        resident  = (ref_line[idx] == line);
        exp_data  = mem_model[a[15:1]];
        exp_reads  = (!is_err && rd && !resident) ? 4 : 0;
        exp_writes = (!is_err && wr) ? 1 : 0;
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        saw_req = 1'b0;
        o_hit = 1'b0; o_err = 1'b0; o_stall = 1'b0; o_data = '0;

        @(posedge clk); #1;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            #2;
            if (Done === 1'b1) begin
                got = 1'b1;
                o_hit = CacheHit; o_err = err; o_stall = Stall; o_data = DataOut;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;

        chk({name, ":done_seen"}, 16'(got), 16'd1);
        chk({name, ":err"}, 16'(o_err), 16'(is_err));
        chk({name, ":cachehit"}, 16'(o_hit), 16'(!is_err && resident));
        chk({name, ":stall_at_done"}, 16'(o_stall), 16'd0);
        if (!is_err && rd) chk({name, ":data"}, o_data, exp_data);
        if (is_err || (rd && resident)) begin
            chk({name, ":same_cycle"}, 16'(cyc), 16'd0);
            chk({name, ":no_mem_req"}, 16'(saw_req), 16'd0);
        end
        chk({name, ":mem_reads"}, 16'(rd_log.size()), 16'(exp_reads));
        if (exp_reads == 4 && rd_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk({name, ":fill_addr"}, rd_log[k], {a[15:3], 2'(k), 1'b0});
            end
        end
        chk({name, ":mem_writes"}, 16'(wr_addr_log.size()), 16'(exp_writes));
        if (exp_writes == 1 && wr_addr_log.size() == 1) begin
            chk({name, ":wr_addr"}, wr_addr_log[0], a);
            chk({name, ":wr_data"}, wr_data_log[0], d);
        end
        if (exp_reads == 4) ref_line[idx] = line;
        last_data = o_data;
    endtask

    initial begin
        int cyc;
        int op;
        logic [15:0] a;
        for (int i = 0; i < 32768; i++) mem_model[i] = 16'($urandom);
        for (int k = 0; k < 4; k++) mem_model[16 + k] = 16'hA000 + 16'(k);
        for (int i = 0; i < 8; i++) ref_line[i] = -1;
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;

        #3;
        chk("reset:Done", 16'(Done), 16'd0);
        chk("reset:Stall", 16'(Stall), 16'd0);
        chk("reset:CacheHit", 16'(CacheHit), 16'd0);
        chk("reset:err", 16'(err), 16'd0);
        chk("reset:mem_rd", 16'(mem_rd), 16'd0);
        chk("reset:mem_wr", 16'(mem_wr), 16'd0);
        chk("reset:mem_addr", mem_addr, 16'h0000);
        chk("reset:mem_wdata", mem_wdata, 16'h0000);
        chk("reset:DataOut", DataOut, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        ack_delay = 2;
        xact(1'b1, 1'b0, 16'h0024, 16'h0000, "cold_rd");
        chk("cold_rd:A002", last_data, 16'hA002);
        xact(1'b1, 1'b0, 16'h0026, 16'h0000, "hit_rd");
        chk("hit_rd:A003", last_data, 16'hA003);

        xact(1'b0, 1'b1, 16'h0022, 16'h1234, "wr_hit");
        xact(1'b1, 1'b0, 16'h0022, 16'h0000, "rd_after_wr");
        chk("rd_after_wr:1234", last_data, 16'h1234);

        xact(1'b1, 1'b0, 16'h0064, 16'h0000, "conflict_rd");
        xact(1'b1, 1'b0, 16'h0024, 16'h0000, "evicted_rd");

        xact(1'b1, 1'b1, 16'h0024, 16'h0000, "err_rdwr");
        xact(1'b1, 1'b0, 16'h0025, 16'h0000, "err_odd_rd");
        xact(1'b0, 1'b1, 16'h0025, 16'h5555, "err_odd_wr");

        xact(1'b0, 1'b1, 16'h01F0, 16'hBEEF, "wr_miss");
        xact(1'b1, 1'b0, 16'h01F0, 16'h0000, "rd_after_wr_miss");
        xact(1'b1, 1'b0, 16'h003E, 16'h0000, "top_idx_miss");
        xact(1'b1, 1'b0, 16'h0038, 16'h0000, "top_idx_hit");

        // Reset after the second fill acknowledgement of a miss.
        ack_delay = 1;
        rd_log.delete();
        @(posedge clk); #1;
        Rd = 1'b1; Addr = 16'h0040;
        cyc = 0;
        while (rd_log.size() < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_fill:acks_before_rst", 16'(rd_log.size()), 16'd2);
        rst = 1'b1; Rd = 1'b0;
        #1;
        chk("rst_fill:mem_rd", 16'(mem_rd), 16'd0);
        chk("rst_fill:Stall", 16'(Stall), 16'd0);
        chk("rst_fill:Done", 16'(Done), 16'd0);
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) ref_line[i] = -1;
        xact(1'b1, 1'b0, 16'h0040, 16'h0000, "post_rst_rd");
        xact(1'b1, 1'b0, 16'h0042, 16'h0000, "post_rst_hit");

        for (int n = 0; n < 80; n++) begin
            ack_delay = $urandom_range(1, 3);
            op = $urandom_range(0, 99);
            a = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 3) << 1));
            if (op < 55)      xact(1'b1, 1'b0, a, 16'h0000, "rnd_rd");
            else if (op < 80) xact(1'b0, 1'b1, a, 16'($urandom), "rnd_wr");
            else if (op < 90) xact(1'b1, 1'b1, a, 16'($urandom), "rnd_err_rdwr");
            else              xact(op[0], !op[0], a | 16'h0001, 16'($urandom), "rnd_err_odd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_mem_responder.md
Name: icache_mem_responder

Overview:
- Responder end of the Rd/Wr/Addr → DataOut/Done/Stall/CacheHit memory-request interface that the fetch and memory stages drive.
- Direct-mapped, write-through, no-write-allocate cache with 4 words per line.
- Backed by an external word-wide memory through a req/ack handshake.
- Serves hits in the request cycle; serves misses via a line-fill state machine.

Parameters:
- IDX_W, 3, index bits; number of lines = 2**IDX_W.
- TAG_W, 16-IDX_W-3, tag width, derived; do not override.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- Addr  in  16  byte address of request; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataOut  out  16  read data, valid when Done=1 and err=0.
- Done  out  1  request complete, one-cycle pulse.
- Stall  out  1  busy; requester holds Addr/Rd/Wr/DataIn stable and issues nothing new.
- CacheHit  out  1  qualifies Done: 1 = served from cache.
- err  out  1  qualifies Done: illegal request.
- mem_addr  out  16  backing-memory word address (byte address, bit 0 = 0).
- mem_wdata  out  16  backing-memory write data.
- mem_rd  out  1  backing read request, held until mem_ack.
- mem_wr  out  1  backing write request, held until mem_ack.
- mem_rdata  in  16  backing read data, valid with mem_ack.
- mem_ack  in  1  backing access complete (≥1 cycle after request).

Behaviour:
Address split:
- offset = Addr[2:1]
- index = Addr[3+IDX_W-1:3]
- tag = Addr[15:3+IDX_W]

Reset (asynchronous):
- All valid bits cleared; state IDLE.
- DataOut=0, Done=0, Stall=0, CacheHit=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Data and tag arrays are not reset.

States: IDLE, FILL (word counter 0..3), RESP, WRITE.

IDLE:
- No request → all outputs 0.
- Error request (Rd&Wr, or (Rd|Wr)&Addr[0]) → Done=1, err=1, CacheHit=0 in the same cycle, combinationally. No state change, no memory access.
- Read hit (valid & tag match) → Done=1, CacheHit=1, DataOut=word, Stall=0, all in the same cycle (combinational). Stay in IDLE.
- Read miss → latch Addr; next state FILL with counter=0; Stall=1 from the next cycle.
- Write (hit or miss) → latch Addr/DataIn. On hit, update the cached word at the clock edge. Next state WRITE.

FILL:
- Stall=1.
- mem_addr = {latched tag, index, counter, 1'b0}; mem_rd=1.
- On mem_ack: store mem_rdata into word[counter], then counter+1.
- After word 3 is acked: write tag, set valid, go to RESP.
- Words are filled in order 0..3 regardless of the requested offset.

RESP:
- Done=1, CacheHit=0, Stall=0, DataOut = requested word; next state IDLE.
- The requester's following request is not sampled until IDLE.

WRITE:
- Stall=1, mem_wr=1, mem_addr = latched Addr, mem_wdata = latched DataIn.
- On mem_ack → next cycle Done=1, CacheHit = 1 if the write hit, else 0; then IDLE.
- Write miss never allocates a line.

Boundary conditions:
- Done is a single-cycle pulse, never asserted while Stall=1.
- Rd/Wr changes while Stall=1 are ignored; latched values are used.
- Reset during FILL: line stays invalid (valid is set only after word 3), and mem_rd drops immediately.
- Reset during WRITE: mem_wr drops immediately; no completion is ever signalled.
- mem_ack outside FILL/WRITE is ignored.
- A read of a line whose tag differs from a valid line evicts it silently; the cache is write-through, so there is no writeback.
- Index wrap: the top index line behaves identically to the others.

Optional Feature:
ICACHE_MEM_RESPONDER_STATS_EN
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each Done with CacheHit=1.
  - miss_count increments on each Done with CacheHit=0 and err=0.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is unchanged.

Test Plan:
1. Cold read: Rd, Addr=16'h0024, backing memory returns word k = 16'hA000+k, ack 2 cycles after each request.
   - Required: 4 mem_rd handshakes at 0x0020, 0x0022, 0x0024, 0x0026.
   - Then Done=1, CacheHit=0, DataOut=16'hA002.
2. Hit after fill: Rd, Addr=16'h0026 → same-cycle Done=1, CacheHit=1, DataOut=16'hA003, no mem_rd.
3. Write hit then read: Wr, Addr=16'h0022, DataIn=16'h1234.
   - Required: one mem_wr to 0x0022; Done with CacheHit=1.
   - Then Rd 0x0022 → hit, DataOut=16'h1234.
4. Conflict eviction: Rd 16'h0064 (same index as 0x0024, different tag) → miss and fill; then Rd 0x0024 → miss again (CacheHit=0).
5. Error cases: Rd&Wr both 1, or Rd with Addr=16'h0025 → same-cycle Done=1, err=1; mem_rd and mem_wr stay 0.
6. Reset mid-fill: assert rst after the 2nd mem_ack of a miss to 0x0040.
   - Required: mem_rd=0 and Stall=0 immediately.
   - Afterwards, Rd 0x0040 misses and performs a full 4-word fill.
